// File: rtl/winocnn_ctrl_pkg.sv
// Shared types and default sizes for the conv scan sequencer.
package winocnn_ctrl_pkg;

    localparam int DATA_W_DEF       = 512;
    localparam int ADDR_W_DEF       = 8;
    localparam int DEPTH_DEF        = 128;
    localparam int CONV_TIMEOUT_DEF = 4096;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        RUN,
        DRN_ADDR,
        DRN_WAIT,
        DRN_HOLD
    } seq_state_e;

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] od;
        logic [8:0] width;
        logic [8:0] height;
        logic       size_type;
    } conv_cfg_t;

endpackage

// File: rtl/scan_out_buffer.sv
// Holds one drained word pair (output_mem1/output_mem2) stable until the host takes it.
module scan_out_buffer #(
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] d1_i,
    input  logic [DATA_W-1:0] d2_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] q1_o,
    output logic [DATA_W-1:0] q2_o
);

    // Clear wins over load so an abort can never leave a stale word visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            q1_o    <= '0;
            q2_o    <= '0;
        end else if (clear_i) begin
            valid_o <= 1'b0;
            q1_o    <= '0;
            q2_o    <= '0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            q1_o    <= d1_i;
            q2_o    <= d2_i;
        end
    end

endmodule

// File: rtl/conv_scan_sequencer.sv
// Host-side sequencer: scan-load input SRAMs, run the conv core, scan-drain both output SRAMs.
module conv_scan_sequencer
    import winocnn_ctrl_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int CONV_TIMEOUT = CONV_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        cfg_id,
    input  logic [7:0]        cfg_od,
    input  logic [8:0]        cfg_width,
    input  logic [8:0]        cfg_height,
    input  logic              cfg_size_type,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_weight,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic              out_last,
    output logic              core_reset,
    output logic              wen,
    output logic              input_mem_scan_mode,
    output logic [1:0]        output_mem_scan_mode,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] data_mem_scan_in,
    output logic [DATA_W-1:0] weight_mem_scan_in,
    output logic [3:0]        total_id,
    output logic [7:0]        total_od,
    output logic [8:0]        total_width,
    output logic [8:0]        total_height,
    output logic              total_size_type,
    input  logic [DATA_W-1:0] output_mem1_scan_out,
    input  logic [DATA_W-1:0] output_mem2_scan_out,
    input  logic              conv_completed,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int                CNT_W     = $clog2(CONV_TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CONV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  BLANK     = CNT_W'(2);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    conv_cfg_t         cfg_q;
    logic              in_ready_q, core_reset_q, wen_q, in_mode_q;
    logic [1:0]        out_mode_q;
    logic [ADDR_W-1:0] scan_addr_q;
    logic [DATA_W-1:0] data_q, weight_q;
    logic              busy_q, done_q, timeout_q;

    logic buf_valid, buf_load, drain_hs, run_done, run_to;

    // Capture happens at the end of WAIT, when the SRAM read for scan_addr is valid.
    assign buf_load = (state_q == DRN_WAIT) && !abort;
    assign drain_hs = (state_q == DRN_HOLD) && buf_valid && out_ready;
    // Completion is blanked for the first RUN cycles while the core comes out of reset.
    assign run_done = (state_q == RUN) && conv_completed && (cnt_q >= BLANK);
    assign run_to   = (state_q == RUN) && !run_done && (cnt_q == CNT_MAX);

    scan_out_buffer #(.DATA_W(DATA_W)) u_obuf (
        .clk     (clk),
        .rst     (reset),
        .load_i  (buf_load),
        .clear_i (abort || drain_hs),
        .d1_i    (output_mem1_scan_out),
        .d2_i    (output_mem2_scan_out),
        .valid_o (buf_valid),
        .q1_o    (out_data1),
        .q2_o    (out_data2)
    );

    // Sequencer FSM; every core-facing and status output is registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            cfg_q        <= '0;
            in_ready_q   <= 1'b0;
            core_reset_q <= 1'b1;
            wen_q        <= 1'b0;
            in_mode_q    <= 1'b0;
            out_mode_q   <= 2'b00;
            scan_addr_q  <= '0;
            data_q       <= '0;
            weight_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else if (abort) begin
            // Same as reset except the sticky timeout flag survives.
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            cfg_q        <= '0;
            in_ready_q   <= 1'b0;
            core_reset_q <= 1'b1;
            wen_q        <= 1'b0;
            in_mode_q    <= 1'b0;
            out_mode_q   <= 2'b00;
            scan_addr_q  <= '0;
            data_q       <= '0;
            weight_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    cfg_q      <= conv_cfg_t'{cfg_id, cfg_od, cfg_width, cfg_height, cfg_size_type};
                    timeout_q  <= 1'b0;
                    busy_q     <= 1'b1;
                    addr_q     <= '0;
                    in_ready_q <= 1'b1;
                    in_mode_q  <= 1'b1;
                    state_q    <= LOAD;
                end
                LOAD: if (in_valid && in_ready_q) begin
                    scan_addr_q <= addr_q;
                    data_q      <= in_data;
                    weight_q    <= in_weight;
                    if (addr_q == LAST_ADDR) begin
                        in_ready_q <= 1'b0;
                        state_q    <= FLUSH;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                // Buses stay put one more cycle so the last word lands in the SRAM.
                FLUSH: begin
                    core_reset_q <= 1'b0;
                    in_mode_q    <= 1'b0;
                    out_mode_q   <= 2'b01;
                    wen_q        <= 1'b1;
                    cnt_q        <= '0;
                    state_q      <= RUN;
                end
                RUN: begin
                    if (run_done || run_to) begin
                        timeout_q   <= timeout_q | run_to;
                        wen_q       <= 1'b0;
                        out_mode_q  <= 2'b11;
                        addr_q      <= '0;
                        scan_addr_q <= '0;
                        state_q     <= DRN_ADDR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DRN_ADDR: state_q <= DRN_WAIT;
                DRN_WAIT: state_q <= DRN_HOLD;
                DRN_HOLD: if (drain_hs) begin
                    if (addr_q == LAST_ADDR) begin
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        core_reset_q <= 1'b1;
                        out_mode_q   <= 2'b00;
                        addr_q       <= '0;
                        scan_addr_q  <= '0;
                        data_q       <= '0;
                        weight_q     <= '0;
                        state_q      <= IDLE;
                    end else begin
                        addr_q      <= addr_q + ADDR_W'(1);
                        scan_addr_q <= addr_q + ADDR_W'(1);
                        state_q     <= DRN_ADDR;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready             = in_ready_q;
    assign out_valid            = buf_valid;
    assign out_last             = buf_valid && (addr_q == LAST_ADDR);
    assign core_reset           = core_reset_q;
    assign wen                  = wen_q;
    assign input_mem_scan_mode  = in_mode_q;
    assign output_mem_scan_mode = out_mode_q;
    assign scan_addr            = scan_addr_q;
    assign data_mem_scan_in     = data_q;
    assign weight_mem_scan_in   = weight_q;
    assign total_id             = cfg_q.id;
    assign total_od             = cfg_q.od;
    assign total_width          = cfg_q.width;
    assign total_height         = cfg_q.height;
    assign total_size_type      = cfg_q.size_type;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign timeout_err          = timeout_q;

endmodule

// File: tb/tb_conv_scan_sequencer.sv
// Randomized bench for conv_scan_sequencer with SRAM models and a word-level reference.
module tb_conv_scan_sequencer;
    import winocnn_ctrl_pkg::*;

    localparam int DW = 512, AW = 8, DEPTH = 128, TMO = 4096;

    logic clk, reset, start, abort;
    logic [3:0] cfg_id;  logic [7:0] cfg_od;  logic [8:0] cfg_width, cfg_height;  logic cfg_size_type;
    logic in_valid, in_ready, out_valid, out_ready, out_last;
    logic [DW-1:0] in_data, in_weight, out_data1, out_data2;
    logic core_reset, wen, input_mem_scan_mode;
    logic [1:0] output_mem_scan_mode;
    logic [AW-1:0] scan_addr;
    logic [DW-1:0] data_mem_scan_in, weight_mem_scan_in, output_mem1_scan_out, output_mem2_scan_out;
    logic [3:0] total_id;  logic [7:0] total_od;  logic [8:0] total_width, total_height;  logic total_size_type;
    logic conv_completed, busy, done, timeout_err;

    conv_scan_sequencer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .CONV_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_id(cfg_id), .cfg_od(cfg_od), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_size_type(cfg_size_type),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
        .out_valid(out_valid), .out_ready(out_ready), .out_data1(out_data1), .out_data2(out_data2),
        .out_last(out_last), .core_reset(core_reset), .wen(wen),
        .input_mem_scan_mode(input_mem_scan_mode), .output_mem_scan_mode(output_mem_scan_mode),
        .scan_addr(scan_addr), .data_mem_scan_in(data_mem_scan_in), .weight_mem_scan_in(weight_mem_scan_in),
        .total_id(total_id), .total_od(total_od), .total_width(total_width), .total_height(total_height),
        .total_size_type(total_size_type),
        .output_mem1_scan_out(output_mem1_scan_out), .output_mem2_scan_out(output_mem2_scan_out),
        .conv_completed(conv_completed), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference storage: words the host sends and words the output SRAMs hold.
    logic [DW-1:0] dq [DEPTH];
    logic [DW-1:0] wq [DEPTH];
    logic [DW-1:0] m1 [256];
    logic [DW-1:0] m2 [256];
    logic [DW-1:0] in_sram [256];
    logic [DW-1:0] wt_sram [256];
    conv_cfg_t cur;

    // Input SRAMs write whatever the scan bus shows while scan mode is on.
    always @(posedge clk) if (input_mem_scan_mode) begin
        in_sram[scan_addr] <= data_mem_scan_in;
        wt_sram[scan_addr] <= weight_mem_scan_in;
    end
    // Output SRAMs: one-cycle registered read of scan_addr.
    always @(posedge clk) begin
        output_mem1_scan_out <= m1[scan_addr];
        output_mem2_scan_out <= m2[scan_addr];
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [DW-1:0] tot();
        return DW'({total_id, total_od, total_width, total_height, total_size_type});
    endfunction

    task automatic fill_mems();
        for (int j = 0; j < DEPTH; j++) begin
            dq[j] = rnd_word(); wq[j] = rnd_word();
        end
        for (int j = 0; j < 256; j++) begin
            m1[j] = rnd_word(); m2[j] = rnd_word();
        end
    endtask

    task automatic drive_cfg(input conv_cfg_t c);
        cfg_id = c.id; cfg_od = c.od; cfg_width = c.width; cfg_height = c.height; cfg_size_type = c.size_type;
    endtask

    task automatic start_run(input conv_cfg_t c);
        cur = c;
        drive_cfg(c);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);
        chk("start_scan_mode", input_mem_scan_mode, 1);
        chk("start_core_reset", core_reset, 1);
        chk("start_timeout_clr", timeout_err, 0);
        chk("start_total", tot(), DW'(c));
    endtask

    task automatic load_words(input bit gaps, input bit poke_start);
        int i = 0, guard = 0, bad = 0;
        logic acc;
        while (i < DEPTH && guard < 4000) begin
            in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data   = dq[i];
            in_weight = wq[i];
            if (poke_start && i == 64) begin
                start = 1'b1;
                drive_cfg(~cur);
            end
            acc = in_valid && in_ready;
            tick();
            start = 1'b0;
            guard++;
            if (acc) begin
                chk("load_addr", scan_addr, i);
                chk("load_data", data_mem_scan_in, dq[i]);
                chk("load_weight", weight_mem_scan_in, wq[i]);
                i++;
            end
        end
        in_valid = 1'b0;
        drive_cfg(cur);
        chk("load_beats", i, DEPTH);
        chk("flush_in_ready", in_ready, 0);
        chk("flush_scan_mode", input_mem_scan_mode, 1);
        chk("flush_core_reset", core_reset, 1);
        chk("flush_addr", scan_addr, DEPTH - 1);
        tick();
        for (int j = 0; j < DEPTH; j++)
            if (in_sram[j] !== dq[j] || wt_sram[j] !== wq[j]) bad++;
        chk("in_sram_contents", bad, 0);
        chk("run_core_reset", core_reset, 0);
        chk("run_wen", wen, 1);
        chk("run_out_mode", output_mem_scan_mode, 2'b01);
        chk("run_in_mode", input_mem_scan_mode, 0);
        chk("run_total", tot(), DW'(cur));
    endtask

    // done_at < 0 means the core never reports completion.
    task automatic run_phase(input int done_at, input bit expect_to);
        int c = 0;
        bit to_early = 0;
        while (output_mem_scan_mode == 2'b01 && c < TMO + 100) begin
            conv_completed = (c == 1) || (c == done_at);
            if (timeout_err) to_early = 1;
            in_valid = 1'($urandom_range(0, 1));
            tick();
            c++;
        end
        conv_completed = 1'b0;
        in_valid = 1'b0;
        chk("run_len", c, expect_to ? TMO : done_at + 1);
        chk("run_timeout_early", to_early, 0);
        chk("drain_out_mode", output_mem_scan_mode, 2'b11);
        chk("drain_wen", wen, 0);
        chk("drain_core_reset", core_reset, 0);
        chk("drain_timeout", timeout_err, expect_to);
        chk("drain_addr0", scan_addr, 0);
    endtask

    // rnd=0: ready high except a 5-cycle stall on word 10. abort_at>=0 aborts on that word.
    task automatic drain(input bit rnd, input int abort_at, input bit exp_to);
        int k = 0, cyc = 0, stall = 0, dones = 0;
        bit hs, aborted = 0;
        while (k < DEPTH && cyc < 3000) begin
            if (done) dones++;
            if (out_valid) begin
                chk("drain_d1", out_data1, m1[k]);
                chk("drain_d2", out_data2, m2[k]);
                chk("drain_last", out_last, k == DEPTH - 1);
                if (k == abort_at) begin
                    aborted = 1;
                    break;
                end
            end
            if (rnd) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = !(k == 10 && out_valid && stall < 5);
                if (!out_ready) begin
                    stall++;
                    chk("bp_addr", scan_addr, 10);
                end
            end
            hs = out_valid && out_ready;
            tick();
            cyc++;
            if (hs) k++;
        end
        out_ready = 1'b0;
        if (aborted) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_out_valid", out_valid, 0);
            chk("abort_core_reset", core_reset, 1);
            chk("abort_modes", {input_mem_scan_mode, output_mem_scan_mode, wen}, 0);
            chk("abort_addr", scan_addr, 0);
            chk("abort_total", tot(), 0);
            chk("abort_timeout_kept", timeout_err, exp_to);
        end else begin
            chk("drain_words", k, DEPTH);
            chk("drain_early_done", dones, 0);
            if (!rnd) chk("drain_cycles", cyc, 3 * DEPTH + 5);
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            chk("done_core_reset", core_reset, 1);
            chk("done_modes", {input_mem_scan_mode, output_mem_scan_mode}, 0);
            chk("done_out_valid", out_valid, 0);
            chk("done_timeout", timeout_err, exp_to);
            tick();
            chk("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        conv_cfg_t c;
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        conv_completed = 1'b0; in_data = '0; in_weight = '0;
        drive_cfg('0);
        repeat (3) tick();
        chk("rst_core_reset", core_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready_valid", {in_ready, out_valid}, 0);
        chk("rst_modes", {input_mem_scan_mode, output_mem_scan_mode, wen}, 0);
        chk("rst_addr", scan_addr, 0);
        chk("rst_status", {done, timeout_err}, 0);
        reset = 1'b0;
        tick();

        // start and abort together: abort wins
        drive_cfg(conv_cfg_t'{4'd3, 8'd3, 9'd3, 9'd3, 1'b1});
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_ready", in_ready, 0);

        // Run A: directed config, back-to-back load, completion at RUN cycle 200, stall on word 10
        fill_mems();
        start_run(conv_cfg_t'{4'd2, 8'd4, 9'd30, 9'd30, 1'b0});
        load_words(0, 0);
        run_phase(200, 0);
        drain(0, -1, 0);

        // Run B: random config, gappy load, random completion, random backpressure
        fill_mems();
        c = conv_cfg_t'($urandom);
        start_run(c);
        load_words(1, 0);
        run_phase($urandom_range(2, 300), 0);
        drain(1, -1, 0);

        // Run C: core never completes
        fill_mems();
        c = conv_cfg_t'($urandom);
        start_run(c);
        load_words(0, 0);
        run_phase(-1, 1);
        drain(1, -1, 1);

        // Run D: start clears timeout, start while busy ignored, abort on drain word 50
        fill_mems();
        c = conv_cfg_t'($urandom);
        start_run(c);
        load_words(1, 1);
        run_phase($urandom_range(2, 100), 0);
        drain(1, 50, 0);

        // Run E: async reset in the middle of a load
        fill_mems();
        start_run(conv_cfg_t'($urandom));
        for (int j = 0; j < 40; j++) begin
            in_valid = 1'b1; in_data = dq[j]; in_weight = wq[j];
            tick();
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_core_reset", core_reset, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_in_ready", in_ready, 0);
        chk("async_rst_addr", scan_addr, 0);
        chk("async_rst_modes", {input_mem_scan_mode, output_mem_scan_mode}, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_idle", {busy, in_ready, out_valid}, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
